frame_free_arbiter: RTL



---
 rtl/frame_buf_pkg.sv | 18 +
 rtl/frame_rr_pick.sv | 31 +++
 rtl/frame_free_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/frame_buf_pkg.sv
// Shared frame-buffer constants and helpers, used by the free-address arbiter, the address
// filler and the free-list FIFO wrapper.
package frame_buf_pkg;

  localparam int unsigned FRAME_ADDR_WIDTH  = 9;
  localparam int unsigned FRAME_TDATA_WIDTH = 16;

  typedef enum logic {
    StEmpty,
    StFull
  } out_st_e;

  // Width of an index into n sources; never zero so a 1-source build still has a port.
  function automatic int unsigned src_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr_i, ascending with wrap.
module frame_rr_pick
  import frame_buf_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = src_idx_w(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  always_comb begin
    int unsigned j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/frame_free_arbiter.sv
// Round-robin merge of freed frame addresses into the free-list FIFO write port.
// Define FRAME_ARB_PRIO0_EN to give source 0 (the post-reset filler) strict priority.
module frame_free_arbiter
  import frame_buf_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned ADDR_WIDTH  = FRAME_ADDR_WIDTH,
  parameter int unsigned TDATA_WIDTH = FRAME_TDATA_WIDTH
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]             s_axis_tvalid,
  output logic [NUM_SRC-1:0]             s_axis_tready,
  input  logic [NUM_SRC-1:0]             src_suppress,
  output logic [TDATA_WIDTH-1:0]         m_axis_tdata,
  output logic [$clog2(NUM_SRC)-1:0]     m_axis_tuser,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           range_err
);

  localparam int unsigned IdxW = src_idx_w(NUM_SRC);

`ifdef FRAME_ARB_PRIO0_EN
  // Pointer only ever ranges over the non-priority sources.
  localparam logic [IdxW-1:0] PtrRst = IdxW'(1);
`else
  localparam logic [IdxW-1:0] PtrRst = '0;
`endif

  out_st_e                state_q, state_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [IdxW-1:0]        tuser_q, tuser_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic                   range_q, range_d;

  logic                   load;
  logic [NUM_SRC-1:0]     eligible;
  logic [NUM_SRC-1:0]     rr_req, rr_gnt;
  logic [IdxW-1:0]        rr_idx;
  logic                   rr_any;
  logic [NUM_SRC-1:0]     win_gnt;
  logic [IdxW-1:0]        win_idx;
  logic                   win_any;
  logic                   win_adv;
  logic [TDATA_WIDTH-1:0] beat;

  assign load     = (state_q == StEmpty) || m_axis_tready;
  assign eligible = s_axis_tvalid & ~src_suppress;

`ifdef FRAME_ARB_PRIO0_EN
  assign rr_req = eligible & {{(NUM_SRC-1){1'b1}}, 1'b0};
`else
  assign rr_req = eligible;
`endif

  frame_rr_pick #(
    .N    (NUM_SRC),
    .IdxW (IdxW)
  ) u_pick (
    .req_i (rr_req),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

  always_comb begin
    win_gnt = rr_gnt;
    win_idx = rr_idx;
    win_any = rr_any;
    win_adv = rr_any;
`ifdef FRAME_ARB_PRIO0_EN
    if (eligible[0]) begin
      win_gnt = {{(NUM_SRC-1){1'b0}}, 1'b1};
      win_idx = '0;
      win_any = 1'b1;
      win_adv = 1'b0;
    end
`endif
  end

  always_comb begin
    beat = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (win_idx == IdxW'(i)) beat = s_axis_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
    end
  end

  assign s_axis_tready = (!areset && load) ? win_gnt : '0;

  always_comb begin
    state_d = state_q;
    tdata_d = tdata_q;
    tuser_d = tuser_q;
    ptr_d   = ptr_q;
    range_d = range_q;
    if (load) begin
      if (win_any) begin
        state_d = StFull;
        tdata_d = TDATA_WIDTH'(beat[ADDR_WIDTH-1:0]);
        tuser_d = win_idx;
        if (|beat[TDATA_WIDTH-1:ADDR_WIDTH]) range_d = 1'b1;
        if (win_adv) begin
          ptr_d = (win_idx == IdxW'(NUM_SRC - 1)) ? PtrRst : win_idx + IdxW'(1);
        end
      end else begin
        state_d = StEmpty;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= StEmpty;
      tdata_q <= '0;
      tuser_q <= '0;
      ptr_q   <= PtrRst;
      range_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tdata_q <= tdata_d;
      tuser_q <= tuser_d;
      ptr_q   <= ptr_d;
      range_q <= range_d;
    end
  end

  assign m_axis_tvalid = (state_q == StFull);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign range_err     = range_q;

endmodule
